// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Fetch stage plus IF/ID pipeline register for the 16-bit, 8-register
// pipelined core. Owns the PC, reads instruction memory combinationally and
// latches the fetched word into IF/ID. Each RUN cycle takes exactly one
// action, in priority order: branch flush, halt, load-use stall, normal fetch.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle pulse, IDLE -> RUN
//   hazard       in   load-use stall request from ID (same cycle)
//   br_taken     in   EX-stage taken branch, flushes IF/ID
//   br_target    in   redirect address when br_taken=1
//   halt         in   ID has decoded HLT in the IF/ID instruction
//   imem_addr    out  instruction-memory address (always equals pc)
//   imem_rdata   in   instruction at imem_addr (combinational read)
//   pc_if_id     out  PC+1 of the instruction held in IF/ID
//   insn_if_id   out  instruction held in IF/ID
//   valid_if_id  out  IF/ID holds a real instruction
//   bubble_id_ex out  ID/EX must load a NOP this cycle (combinational)
//   halted       out  core has executed HLT (registered)
//   stall_cnt    out  saturating count of hazard-stall cycles
//   flush_cnt    out  saturating count of branch flushes
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSN_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hazard,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              halt,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc_if_id,
  output logic [INSN_W-1:0] insn_if_id,
  output logic              valid_if_id,
  output logic              bubble_id_ex,
  output logic              halted,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_if_id;
  logic [INSN_W-1:0] r_insn_if_id;
  logic              r_valid_if_id;
  logic              r_halted;
  logic [15:0]       r_stall_cnt;
  logic [15:0]       r_flush_cnt;

  logic              w_run;
  logic              w_flush;
  logic              w_halt;
  logic              w_stall;
  logic              w_normal;
  logic [PC_W-1:0]   w_pc_inc;

  assign w_run    = (r_state == ST_RUN);
  // Halt and hazard both refer to the instruction in IF/ID, so they only
  // count when that slot is occupied; a flush discards both.
  assign w_flush  = w_run & br_taken;
  assign w_halt   = w_run & ~br_taken & halt & r_valid_if_id;
  assign w_stall  = w_run & ~br_taken & ~w_halt & hazard & r_valid_if_id;
  assign w_normal = w_run & ~w_flush & ~w_halt & ~w_stall;
  assign w_pc_inc = r_pc + PC_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_pc_if_id    <= '0;
      r_insn_if_id  <= '0;
      r_valid_if_id <= 1'b0;
      r_halted      <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_flush) begin
            r_pc          <= br_target;
            r_valid_if_id <= 1'b0;
            r_insn_if_id  <= '0;
            if (r_flush_cnt != 16'hFFFF) begin
              r_flush_cnt <= r_flush_cnt + 16'd1;
            end
          end else if (w_halt) begin
            r_valid_if_id <= 1'b0;
            r_halted      <= 1'b1;
            r_state       <= ST_HALTED;
          end else if (w_stall) begin
            if (r_stall_cnt != 16'hFFFF) begin
              r_stall_cnt <= r_stall_cnt + 16'd1;
            end
          end else if (w_normal) begin
            r_pc          <= w_pc_inc;
            r_pc_if_id    <= w_pc_inc;
            r_insn_if_id  <= imem_rdata;
            r_valid_if_id <= 1'b1;
          end
        end
        default: begin
          // HALTED: everything frozen until reset.
        end
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign pc_if_id     = r_pc_if_id;
  assign insn_if_id   = r_insn_if_id;
  assign valid_if_id  = r_valid_if_id & w_run;
  assign bubble_id_ex = w_flush | w_halt | w_stall;
  assign halted       = r_halted;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule
